// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-slot (main + skid) pipeline register with flush, hold and exception kill
module pipe_stage_reg #(
  parameter int                 DATA_W         = 128,
  parameter int                 EXC_W          = 5,
  parameter logic [EXC_W-1:0]   EXC_NONE       = '0,
  parameter logic [DATA_W-1:0]  NOP_DATA       = '0,
  parameter bit                 KILL_AFTER_EXC = 1'b1
) (
  input  logic              cpu_clk_75M,
  input  logic              cpu_rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [EXC_W-1:0]  in_exc_i,
  input  logic [31:0]       in_pc_i,
  input  logic              in_delay_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [EXC_W-1:0]  out_exc_o,
  output logic [31:0]       out_pc_o,
  output logic              out_delay_o,
  output logic [1:0]        occupancy_o,
  output logic              exc_pending_o,
  output logic [31:0]       bp_cycles_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic [31:0]       pc;
    logic              delay;
  } entry_t;

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic [31:0] bp_q, bp_d;
  logic   acc, rel;

  assign in_entry = '{data: in_data_i, exc: in_exc_i, pc: in_pc_i, delay: in_delay_i};

  assign exc_pending_o = (main_valid_q && (main_q.exc != EXC_NONE)) ||
                         (skid_valid_q && (skid_q.exc != EXC_NONE));
  assign occupancy_o   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign in_ready_o  = ~skid_valid_q & ~hold_i & ~flush_i & ~(KILL_AFTER_EXC & exc_pending_o);
  assign out_valid_o = main_valid_q & ~hold_i & ~flush_i;

  assign acc = in_valid_i & in_ready_o;
  assign rel = out_valid_o & out_ready_i;

  // Output payload is masked by main_valid only; hold does not hide it.
  assign out_data_o  = main_valid_q ? main_q.data  : NOP_DATA;
  assign out_exc_o   = main_valid_q ? main_q.exc   : EXC_NONE;
  assign out_pc_o    = main_valid_q ? main_q.pc    : 32'd0;
  assign out_delay_o = main_valid_q ? main_q.delay : 1'b0;
  assign bp_cycles_o = bp_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && skid_valid_q) begin
      if (rel) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (acc && rel) begin
        main_d = in_entry;
      end else if (acc) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end else if (rel) begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end
  end

  always_comb begin
    bp_d = bp_q;
    if (main_valid_q && !out_ready_i && !hold_i && (bp_q != 32'hFFFF_FFFF)) begin
      bp_d = bp_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      bp_q         <= 32'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      bp_q         <= bp_d;
    end
  end

  // Payload slots are never cleared; the valid bits alone decide visibility.
  always_ff @(posedge cpu_clk_75M) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and randomized bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int EW = 5;
  localparam logic [DW-1:0] NOP = {4{32'hA5A5_0F0F}};

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] exc;
    logic [31:0]   pc;
    logic          delay;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, hold = 1'b0;
  logic in_valid = 1'b0, in_delay = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_exc = '0;
  logic [31:0]   in_pc = '0;
  logic in_ready, out_valid, out_delay, exc_pending;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exc;
  logic [31:0]   out_pc, bp;
  logic [1:0]    occ;

  ent_t        q[$];
  logic [31:0] bp_m = 32'd0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .EXC_NONE('0), .NOP_DATA(NOP), .KILL_AFTER_EXC(1'b1)) dut (
    .cpu_clk_75M(clk), .cpu_rst(rst), .flush_i(flush), .hold_i(hold),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_exc_i(in_exc),
    .in_pc_i(in_pc), .in_delay_i(in_delay),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_exc_o(out_exc),
    .out_pc_o(out_pc), .out_delay_o(out_delay),
    .occupancy_o(occ), .exc_pending_o(exc_pending), .bp_cycles_o(bp)
  );

  function automatic logic m_exc();
    foreach (q[i]) if (q[i].exc != '0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_in_ready();
    return (q.size() < 2) && !hold && !flush && !m_exc();
  endfunction

  function automatic logic m_out_valid();
    return (q.size() > 0) && !hold && !flush;
  endfunction

  function automatic ent_t m_front();
    ent_t e;
    e = '0;
    e.data = NOP;
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  task automatic tick();
    logic a, r, grow;
    ent_t e;
    a    = in_valid && m_in_ready();
    r    = m_out_valid() && out_ready;
    grow = (q.size() > 0) && !out_ready && !hold;
    e    = {in_data, in_exc, in_pc, in_delay};
    if (rst) begin
      q.delete();
      bp_m = 32'd0;
    end else begin
      if (grow && bp_m != 32'hFFFF_FFFF) bp_m = bp_m + 32'd1;
      if (flush) q.delete();
      else begin
        if (r) void'(q.pop_front());
        if (a) q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; hold = 0; in_valid = 0; out_ready = 0;
    in_data = '0; in_exc = '0; in_pc = '0; in_delay = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({occ, exc_pending, out_valid, in_ready} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", {occ, exc_pending, out_valid, in_ready}, 5'b00001);
    end
    checks++;
    if (out_data !== NOP) begin
      errors++; $display("FAIL reset_data: got %h want %h", out_data, NOP);
    end
    checks++;
    if ({out_exc, out_pc, out_delay} !== '0) begin
      errors++; $display("FAIL reset_side: got exc=%h pc=%h dly=%b want zeros", out_exc, out_pc, out_delay);
    end
    checks++;
    if (bp !== 32'd0) begin
      errors++; $display("FAIL reset_bp: got %0d want 0", bp);
    end
  endtask

  task automatic test_streaming();
    idle_inputs();
    out_ready = 1; in_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      in_data = DW'(k); in_pc = 32'h1000 + 32'(4 * k);
      tick();
      checks++;
      if (!(out_valid === 1'b1 && out_data === DW'(k) && out_pc === 32'h1000 + 32'(4 * k) && occ === 2'd1)) begin
        errors++; $display("FAIL stream_%0d: got v=%b d=%0h pc=%h occ=%0d want v=1 d=%0h occ=1", k, out_valid, out_data, out_pc, occ, k);
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got occ=%0d v=%b want 0 0", occ, out_valid);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1; in_data = DW'(128'hA); in_exc = '0; tick();
    in_data = DW'(128'hB); tick();
    in_valid = 0;
    checks++;
    if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== DW'(128'hA)) begin
      errors++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%0h want 2 0 a", occ, in_ready, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bp !== bp_m) begin
        errors++; $display("FAIL bp_count_%0d: got %0d want %0d", i, bp, bp_m);
      end
      tick();
    end
    checks++;
    if (bp !== bp_m) begin
      errors++; $display("FAIL bp_count_end: got %0d want %0d", bp, bp_m);
    end
    out_ready = 1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(128'hA)) begin
      errors++; $display("FAIL bp_first: got v=%b d=%0h want 1 a", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(128'hB) || occ !== 2'd1) begin
      errors++; $display("FAIL bp_second: got v=%b d=%0h occ=%0d want 1 b 1", out_valid, out_data, occ);
    end
    tick();
    checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got occ=%0d v=%b want 0 0", occ, out_valid);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1; in_data = DW'(128'h11); tick();
    in_data = DW'(128'h22); tick();
    flush = 1; in_data = DW'(128'h33);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_comb: got rdy=%b v=%b want 0 0", in_ready, out_valid);
    end
    tick();
    flush = 0; in_valid = 0;
    #1;
    checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP) begin
      errors++; $display("FAIL flush_after: got occ=%0d v=%b d=%h want 0 0 nop", occ, out_valid, out_data);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    in_valid = 1; in_data = DW'(128'h55); in_delay = 1; tick();
    in_valid = 0; in_delay = 0; hold = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occ !== 2'd1 || out_data !== DW'(128'h55)) begin
        errors++; $display("FAIL hold_%0d: got v=%b rdy=%b occ=%0d d=%0h want 0 0 1 55", i, out_valid, in_ready, occ, out_data);
      end
      tick();
    end
    hold = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(128'h55) || out_delay !== 1'b1) begin
      errors++; $display("FAIL hold_release: got v=%b d=%0h dly=%b want 1 55 1", out_valid, out_data, out_delay);
    end
    tick();
    checks++;
    if (occ !== 2'd0) begin
      errors++; $display("FAIL hold_drained: got occ=%0d want 0", occ);
    end
  endtask

  task automatic test_exc_block();
    idle_inputs();
    in_valid = 1; in_exc = 5'd4; in_data = DW'(128'h77); tick();
    in_exc = '0; in_data = DW'(128'h78);
    #1;
    checks++;
    if (exc_pending !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL exc_block: got pend=%b rdy=%b want 1 0", exc_pending, in_ready);
    end
    tick();
    checks++;
    if (occ !== 2'd1 || out_exc !== 5'd4) begin
      errors++; $display("FAIL exc_refused: got occ=%0d exc=%0d want 1 4", occ, out_exc);
    end
    in_valid = 0; out_ready = 1; tick();
    out_ready = 0;
    #1;
    checks++;
    if (exc_pending !== 1'b0 || in_ready !== 1'b1 || occ !== 2'd0) begin
      errors++; $display("FAIL exc_released: got pend=%b rdy=%b occ=%0d want 0 1 0", exc_pending, in_ready, occ);
    end
    in_valid = 1; in_exc = 5'd9; tick();
    in_valid = 0; in_exc = '0; flush = 1; tick();
    flush = 0;
    #1;
    checks++;
    if (exc_pending !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL exc_flushed: got pend=%b rdy=%b want 0 1", exc_pending, in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    in_valid = 1; in_data = DW'(128'hC1); tick();
    in_data = DW'(128'hC2); tick();
    in_valid = 0;
    repeat (6) tick();
    checks++;
    if (bp !== 32'd7 || occ !== 2'd2) begin
      errors++; $display("FAIL rst_pre: got bp=%0d occ=%0d want 7 2", bp, occ);
    end
    rst = 1; hold = 1; in_valid = 1; tick();
    rst = 0; hold = 0; in_valid = 0;
    #1;
    checks++;
    if (occ !== 2'd0 || bp !== 32'd0 || out_data !== NOP || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got occ=%0d bp=%0d d=%h v=%b want 0 0 nop 0", occ, bp, out_data, out_valid);
    end
  endtask

  task automatic test_random();
    ent_t exp;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      hold      = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_exc    = ($urandom_range(0, 7) == 0) ? EW'($urandom_range(1, 31)) : '0;
      in_pc     = $urandom;
      in_delay  = 1'($urandom);
      #1;
      exp = m_front();
      checks++;
      if ({in_ready, out_valid, occ, exc_pending} !== {m_in_ready(), m_out_valid(), 2'(q.size()), m_exc()}) begin
        errors++; $display("FAIL rand_ctrl_%0d: got %b want %b", c, {in_ready, out_valid, occ, exc_pending},
                           {m_in_ready(), m_out_valid(), 2'(q.size()), m_exc()});
      end
      checks++;
      if ({out_data, out_exc, out_pc, out_delay} !== exp) begin
        errors++; $display("FAIL rand_out_%0d: got d=%h e=%0d pc=%h want d=%h e=%0d pc=%h", c, out_data, out_exc, out_pc,
                           exp.data, exp.exc, exp.pc);
      end
      checks++;
      if (bp !== bp_m) begin
        errors++; $display("FAIL rand_bp_%0d: got %0d want %0d", c, bp, bp_m);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_hold();
    test_exc_block();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128; payload width in bits.
REQ-002 SHALL have parameter EXC_W, default 5; exception-code width in bits.
REQ-003 SHALL have parameter EXC_NONE, default 0; the "no exception" code.
REQ-004 SHALL have parameter NOP_DATA, default all-zero; payload presented when the stage is empty.
REQ-005 SHALL have parameter KILL_AFTER_EXC, default 1; when 1, the stage refuses new entries while a stored entry carries an exception.
REQ-006 SHALL have port cpu_clk_75M, input, 1 bit; the single clock, rising edge.
REQ-007 SHALL have port cpu_rst, input, 1 bit; reset, synchronous, active-high.
REQ-008 SHALL have port flush_i, input, 1 bit; discard all stored entries.
REQ-009 SHALL have port hold_i, input, 1 bit; legacy stall that freezes both handshakes.
REQ-010 SHALL have port in_valid_i, input, 1 bit; upstream entry valid.
REQ-011 SHALL have port in_ready_o, output, 1 bit; stage accepts an entry.
REQ-012 SHALL have port in_data_i, input, DATA_W bits; upstream payload.
REQ-013 SHALL have port in_exc_i, input, EXC_W bits; upstream exception code.
REQ-014 SHALL have port in_pc_i, input, 32 bits; upstream instruction PC.
REQ-015 SHALL have port in_delay_i, input, 1 bit; upstream delay-slot flag.
REQ-016 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, DATA_W), out_exc_o (output, EXC_W), out_pc_o (output, 32), out_delay_o (output, 1); the downstream side.
REQ-017 SHALL have port occupancy_o, output, 2 bits; number of stored entries, 0..2.
REQ-018 SHALL have port exc_pending_o, output, 1 bit; some stored entry has exc != EXC_NONE.
REQ-019 SHALL have port bp_cycles_o, output, 32 bits; downstream back-pressure cycle counter.

Function
REQ-020 SHALL hold storage in two slots: main (drives outputs) and skid; entries SHALL leave in arrival order.
REQ-021 SHALL define acc = in_valid_i & in_ready_o, and rel = out_valid_o & out_ready_i.
REQ-022 SHALL drive in_ready_o = ~skid_valid & ~hold_i & ~flush_i & ~(KILL_AFTER_EXC & exc_pending_o).
REQ-023 SHALL drive out_valid_o = main_valid & ~hold_i & ~flush_i.
REQ-024 SHALL drive out_data_o = NOP_DATA, out_exc_o = EXC_NONE, out_pc_o = 0 and out_delay_o = 0 whenever main_valid = 0.
REQ-025 SHALL apply these transitions on occupancy 0, acc: the entry goes to main (1 cycle latency); no acc: stay 0.
REQ-026 SHALL apply these transitions on occupancy 1: acc & rel: main <= input, count stays 1; acc only: skid <= input, count 2; rel only: count 0.
REQ-027 SHALL apply these transitions on occupancy 2: rel: main <= skid, count 1; acc is impossible because in_ready_o = 0.
REQ-028 SHALL act on flush_i = 1 at the next edge: clear main_valid and skid_valid; flush SHALL override acc, rel and hold_i; no handshake completes in that cycle.
REQ-029 SHALL, with hold_i = 1 and flush_i = 0, keep all state unchanged.
REQ-030 SHALL make occupancy_o and exc_pending_o pure functions of the registered valids and slot exception codes.
REQ-031 SHALL increment bp_cycles_o by 1 each cycle with main_valid & ~out_ready_i & ~hold_i, saturating at 0xFFFFFFFF; flush SHALL NOT clear it.
REQ-032 SHALL hold payload registers without clearing when a slot is invalid; only the valid bits gate visibility.

Reset
REQ-033 SHALL, while cpu_rst = 1 at a rising edge, clear main_valid, skid_valid and bp_cycles_o to 0.
REQ-034 SHALL, after reset, show occupancy_o = 0, exc_pending_o = 0, out_valid_o = 0, and NOP_DATA/EXC_NONE on the outputs.
REQ-035 SHALL give reset priority over flush_i and hold_i; reset mid-transfer SHALL discard both slots.

Verification
REQ-036 SHALL cover streaming: in_valid = 1 every cycle with data 1,2,3,4 and out_ready = 1 -> out_data 1,2,3,4 on consecutive cycles, one cycle later, occupancy stays 1.
REQ-037 SHALL cover back-pressure: push A,B with out_ready = 0 -> occupancy 2, in_ready 0, bp_cycles increments each cycle; out_ready = 1 -> A then B, no loss or duplication.
REQ-038 SHALL cover flush: occupancy 2, flush_i = 1 together with in_valid = 1 -> next cycle occupancy 0, out_valid 0, the input was not accepted.
REQ-039 SHALL cover hold: occupancy 1 with hold_i = 1 for 3 cycles and out_ready = 1 -> out_valid 0, state unchanged, entry released on the first cycle after hold drops.
REQ-040 SHALL cover exception blocking: KILL_AFTER_EXC = 1, accept entry with in_exc = 4 -> exc_pending 1, in_ready 0 until that entry is released or flushed, then in_ready 1.
REQ-041 SHALL cover reset: cpu_rst asserted with occupancy 2 and bp_cycles = 7 -> next cycle occupancy 0, bp_cycles 0, out_data = NOP_DATA.
